uart_cmd_client: RTL and testbench

//  Host-side command/response engine for the UART block. It transmits a buffered command string

---
 rtl/uart_cmd_client.sv | 189 ++++++++++++++++++
 tb/tb_uart_cmd_client.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_client.sv
// Host-side command/response engine: pushes a buffered command plus terminator into the
// UART TX FIFO, then drains the UART RX FIFO into a response buffer until prompt or timeout.
module uart_cmd_client #(
    parameter int                DBIT    = 8,
    parameter int                CMD_W   = 4,
    parameter int                RSP_W   = 5,
    parameter logic [DBIT-1:0]   TERM    = 8'h0D,
    parameter logic [DBIT-1:0]   PROMPT  = 8'h3E,
    parameter int                TO_BITS = 24,
    parameter int                TIMEOUT = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_we,
    input  logic [CMD_W-1:0]   cmd_addr,
    input  logic [DBIT-1:0]    cmd_wdata,
    input  logic [CMD_W:0]     cmd_len,
    input  logic               start,
    output logic               busy,
    output logic               done_tick,
    output logic [3:0]         status,
    input  logic [RSP_W-1:0]   resp_addr,
    output logic [DBIT-1:0]    resp_data,
    output logic [RSP_W:0]     resp_len,
    input  logic               tx_full,
    output logic               wr_uart,
    output logic [DBIT-1:0]    w_data,
    input  logic               rx_empty,
    input  logic [DBIT-1:0]    r_data,
    output logic               rd_uart,
    input  logic               e_parity,
    input  logic               e_frame
);

    localparam int                 CMD_DEPTH = 1 << CMD_W;
    localparam int                 RSP_DEPTH = 1 << RSP_W;
    localparam logic [CMD_W:0]     CMD_MAX   = (CMD_W+1)'(CMD_DEPTH);
    localparam logic [RSP_W:0]     RSP_MAX   = (RSP_W+1)'(RSP_DEPTH);
    localparam logic [TO_BITS-1:0] TO_LAST   = TO_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_SEND_TERM,
        S_RECV,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CMD_W:0]       len_q, len_d;
    logic [CMD_W:0]       idx_q, idx_d;
    logic [RSP_W:0]       resp_len_q, resp_len_d;
    logic [3:0]           status_q, status_d;
    logic [TO_BITS-1:0]   to_cnt_q, to_cnt_d;
    logic                 e_parity_q, e_parity_d;
    logic                 e_frame_q, e_frame_d;

    logic [DBIT-1:0]      cmd_buf_q [CMD_DEPTH];
    logic [DBIT-1:0]      resp_buf_q [RSP_DEPTH];
    logic                 cmd_wr;
    logic                 rsp_wr;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        resp_len_d = resp_len_q;
        status_d   = status_q;
        to_cnt_d   = to_cnt_q;
        e_parity_d = e_parity;
        e_frame_d  = e_frame;
        busy       = 1'b0;
        done_tick  = 1'b0;
        wr_uart    = 1'b0;
        w_data     = cmd_buf_q[idx_q[CMD_W-1:0]];
        rd_uart    = 1'b0;
        cmd_wr     = 1'b0;
        rsp_wr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // the buffer write commits on the same edge, so a coincident start sees it
                cmd_wr = cmd_we;
                if (start) begin
                    len_d      = (cmd_len > CMD_MAX) ? CMD_MAX : cmd_len;
                    idx_d      = '0;
                    status_d   = '0;
                    resp_len_d = '0;
                    to_cnt_d   = '0;
                    state_d    = (cmd_len == '0) ? S_SEND_TERM : S_SEND;
                end
            end

            S_SEND: begin
                busy    = 1'b1;
                wr_uart = !tx_full;
                if (!tx_full) begin
                    idx_d = idx_q + (CMD_W+1)'(1);
                    if (idx_q == len_q - (CMD_W+1)'(1)) begin
                        state_d = S_SEND_TERM;
                    end
                end
            end

            S_SEND_TERM: begin
                busy    = 1'b1;
                wr_uart = !tx_full;
                w_data  = TERM;
                if (!tx_full) begin
                    state_d = S_RECV;
                end
            end

            S_RECV: begin
                busy    = 1'b1;
                rd_uart = !rx_empty;
                if (e_parity && !e_parity_q) begin
                    status_d[2] = 1'b1;
                end
                if (e_frame && !e_frame_q) begin
                    status_d[3] = 1'b1;
                end
                // a pop in the timeout cycle takes priority over the timeout
                if (!rx_empty) begin
                    to_cnt_d = '0;
                    if (r_data == PROMPT) begin
                        state_d = S_DONE;
                    end else if (resp_len_q < RSP_MAX) begin
                        rsp_wr     = 1'b1;
                        resp_len_d = resp_len_q + (RSP_W+1)'(1);
                    end else begin
                        status_d[1] = 1'b1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    status_d[0] = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_BITS'(1);
                end
            end

            S_DONE: begin
                done_tick = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            resp_len_q <= '0;
            status_q   <= '0;
            to_cnt_q   <= '0;
            e_parity_q <= 1'b0;
            e_frame_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            resp_len_q <= resp_len_d;
            status_q   <= status_d;
            to_cnt_q   <= to_cnt_d;
            e_parity_q <= e_parity_d;
            e_frame_q  <= e_frame_d;
        end
    end

    // buffers are plain storage and keep their contents across reset
    always_ff @(posedge clk) begin
        if (cmd_wr) begin
            cmd_buf_q[cmd_addr] <= cmd_wdata;
        end
        if (rsp_wr) begin
            resp_buf_q[resp_len_q[RSP_W-1:0]] <= r_data;
        end
    end

    assign resp_data = resp_buf_q[resp_addr];
    assign resp_len  = resp_len_q;
    assign status    = status_q;

endmodule

// File: tb/tb_uart_cmd_client.sv
// Scoreboard bench for uart_cmd_client: stimulus queues expected TX bytes and completions,
// a negedge monitor pops and compares them whenever the DUT pushes a byte or signals done.
module tb_uart_cmd_client;

    localparam int DBIT    = 8;
    localparam int CMD_W   = 4;
    localparam int RSP_W   = 2;
    localparam int TIMEOUT = 100;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_we;
    logic [CMD_W-1:0]   cmd_addr;
    logic [DBIT-1:0]    cmd_wdata;
    logic [CMD_W:0]     cmd_len;
    logic               start;
    logic               busy;
    logic               done_tick;
    logic [3:0]         status;
    logic [RSP_W-1:0]   resp_addr;
    logic [DBIT-1:0]    resp_data;
    logic [RSP_W:0]     resp_len;
    logic               tx_full;
    logic               wr_uart;
    logic [DBIT-1:0]    w_data;
    logic               rx_empty;
    logic [DBIT-1:0]    r_data;
    logic               rd_uart;
    logic               e_parity;
    logic               e_frame;

    uart_cmd_client #(
        .RSP_W   (RSP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .start     (start),
        .busy      (busy),
        .done_tick (done_tick),
        .status    (status),
        .resp_addr (resp_addr),
        .resp_data (resp_data),
        .resp_len  (resp_len),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .e_parity  (e_parity),
        .e_frame   (e_frame)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]   exp_tx [$];
    logic [6:0]   exp_done [$];
    int unsigned  push_log [$];
    int unsigned  cyc = 0;
    int unsigned  done_cnt = 0;
    int unsigned  done_cyc = 0;

    // RX FIFO model: stimulus appends at rx_wr, DUT pops advance rx_rd
    logic [7:0]   rx_stream [0:63];
    int unsigned  rx_wr = 0;
    int unsigned  rx_rd = 0;
    assign rx_empty = (rx_rd == rx_wr);
    assign r_data   = rx_stream[rx_rd % 64];

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rd_uart) rx_rd <= rx_rd + 1;
    end

    initial forever begin
        @(negedge clk);
        if (tx_full) begin
            tests++;
            if (wr_uart) begin
                fails++;
                $display("FAIL push_while_full: wr_uart=%0b required 0", wr_uart);
            end
        end
        if (wr_uart) begin
            tests++;
            if (exp_tx.size() == 0) begin
                fails++;
                $display("FAIL tx_unexpected: w_data=%02h required no push", w_data);
            end else begin
                logic [7:0] e;
                e = exp_tx.pop_front();
                if (w_data !== e) begin
                    fails++;
                    $display("FAIL tx_byte: w_data=%02h required %02h", w_data, e);
                end
            end
            push_log.push_back(cyc);
        end
        if (done_tick) begin
            done_cnt++;
            done_cyc = cyc;
            tests++;
            if (exp_done.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected: status=%04b resp_len=%0d required no done", status, resp_len);
            end else begin
                logic [6:0] e;
                e = exp_done.pop_front();
                if ({status, resp_len} !== e) begin
                    fails++;
                    $display("FAIL done_result: status=%04b resp_len=%0d required status=%04b resp_len=%0d",
                             status, resp_len, e[6:3], e[2:0]);
                end
            end
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL busy_at_done: busy=%0b required 0", busy);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cmd(input logic [CMD_W-1:0] a, input logic [7:0] d);
        cmd_we    = 1'b1;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_we    = 1'b0;
    endtask

    task automatic go(input logic [CMD_W:0] len);
        cmd_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        rx_stream[rx_wr % 64] = b;
        rx_wr++;
    endtask

    task automatic wait_done(input string name, input int budget);
        int unsigned base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        check(name, done_cnt - base, 1);
    endtask

    task automatic wait_pushes(input string name, input int unsigned target, input int budget);
        int n;
        n = 0;
        while (push_log.size() < target && n < budget) begin
            tick();
            n++;
        end
        check(name, (push_log.size() >= target) ? 32'd1 : 32'd0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned dc;
        logic [7:0] t3_exp [3];
        t3_exp = '{8'h4F, 8'h4B, 8'h0D};

        reset = 1'b1; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_len = '0;
        start = 1'b0; resp_addr = '0; tx_full = 1'b0; e_parity = 1'b0; e_frame = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done_tick, 0);
        check("rst_wr", wr_uart, 0);
        check("rst_rd", rd_uart, 0);
        check("rst_status", status, 0);
        check("rst_resp_len", resp_len, 0);
        reset = 1'b0;
        tick();

        // T1 + T3: "ATZ" then "OK\r>"
        wr_cmd(0, 8'h41); wr_cmd(1, 8'h54); wr_cmd(2, 8'h5A);
        feed(8'h4F); feed(8'h4B); feed(8'h0D); feed(8'h3E);
        exp_tx.push_back(8'h41); exp_tx.push_back(8'h54); exp_tx.push_back(8'h5A); exp_tx.push_back(8'h0D);
        exp_done.push_back({4'b0000, 3'd3});
        base = push_log.size();
        go(5'd3);
        wait_done("t1_done", 200);
        check("t1_pushes", push_log.size() - base, 4);
        if (push_log.size() >= base + 4) check("t1_span", push_log[base+3] - push_log[base], 3);
        for (int i = 0; i < 3; i++) begin
            resp_addr = RSP_W'(i);
            #1;
            check("t3_resp_byte", resp_data, t3_exp[i]);
        end
        check("t3_drained", rx_rd, rx_wr);

        // T2: TX back-pressure for 5 cycles after the second push
        feed(8'h4F); feed(8'h4B); feed(8'h0D); feed(8'h3E);
        exp_tx.push_back(8'h41); exp_tx.push_back(8'h54); exp_tx.push_back(8'h5A); exp_tx.push_back(8'h0D);
        exp_done.push_back({4'b0000, 3'd3});
        base = push_log.size();
        go(5'd3);
        wait_pushes("t2_two_pushes", base + 2, 50);
        tx_full = 1'b1;
        repeat (5) tick();
        tx_full = 1'b0;
        wait_done("t2_done", 200);
        check("t2_pushes", push_log.size() - base, 4);
        if (push_log.size() >= base + 4) check("t2_span", push_log[base+3] - push_log[base], 8);

        // T4: timeout with empty command
        exp_tx.push_back(8'h0D);
        exp_done.push_back({4'b0001, 3'd0});
        base = push_log.size();
        go(5'd0);
        wait_done("t4_done", 300);
        if (push_log.size() > base) check("t4_latency", done_cyc - push_log[base], 101);

        // T5: response overflow
        for (int i = 1; i <= 6; i++) feed(8'(i));
        feed(8'h3E);
        exp_tx.push_back(8'h41); exp_tx.push_back(8'h0D);
        exp_done.push_back({4'b0010, 3'd4});
        go(5'd1);
        wait_done("t5_done", 200);
        for (int i = 0; i < 4; i++) begin
            resp_addr = RSP_W'(i);
            #1;
            check("t5_resp_byte", resp_data, 8'(i + 1));
        end
        check("t5_drained", rx_rd, rx_wr);

        // parity and frame error edges during RECV
        exp_tx.push_back(8'h0D);
        exp_done.push_back({4'b1100, 3'd0});
        base = push_log.size();
        go(5'd0);
        wait_pushes("err_term", base + 1, 50);
        repeat (3) tick();
        e_parity = 1'b1; e_frame = 1'b1;
        tick();
        e_parity = 1'b0; e_frame = 1'b0;
        tick();
        feed(8'h3E);
        wait_done("err_done", 200);

        // length clamp, coincident write+start, write while busy ignored
        for (int i = 0; i < 16; i++) wr_cmd(CMD_W'(i), 8'(8'h10 + i));
        exp_tx.push_back(8'hA5);
        for (int i = 1; i < 16; i++) exp_tx.push_back(8'(8'h10 + i));
        exp_tx.push_back(8'h0D);
        exp_done.push_back({4'b0000, 3'd0});
        feed(8'h3E);
        base = push_log.size();
        cmd_we = 1'b1; cmd_addr = '0; cmd_wdata = 8'hA5; cmd_len = 5'd20; start = 1'b1;
        tick();
        start = 1'b0; cmd_addr = 4'd15; cmd_wdata = 8'hFF;
        tick();
        cmd_we = 1'b0;
        wait_done("clamp_done", 200);
        check("clamp_pushes", push_log.size() - base, 17);

        // T6: reset mid-SEND, then resend from byte 0
        wr_cmd(0, 8'h41); wr_cmd(1, 8'h54); wr_cmd(2, 8'h5A);
        exp_tx.push_back(8'h41); exp_tx.push_back(8'h54);
        base = push_log.size();
        dc = done_cnt;
        go(5'd3);
        wait_pushes("t6_two_pushes", base + 2, 50);
        reset = 1'b1;
        #1;
        check("t6_wr_uart", wr_uart, 0);
        check("t6_busy", busy, 0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        check("t6_no_done", done_cnt - dc, 0);
        check("t6_pushes", push_log.size() - base, 2);
        exp_tx.push_back(8'h41); exp_tx.push_back(8'h54); exp_tx.push_back(8'h5A); exp_tx.push_back(8'h0D);
        exp_done.push_back({4'b0000, 3'd0});
        feed(8'h3E);
        go(5'd3);
        wait_done("t6_resend_done", 200);

        check("tx_queue_empty", exp_tx.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
